// File: rtl/tile_map_server.sv
// Tile map for the current level: combinational pixel-coordinate lookups on two ports,
// a ROM loader FSM, and a single-tile runtime write port.
module tile_map_server #(
    parameter int           MAP_W    = 20,
    parameter int           MAP_H    = 15,
    parameter logic [2:0]   OOB_TYPE = 3'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic [1:0]  level_sel,
    output logic [10:0] rom_addr,
    input  logic [2:0]  rom_data,
    output logic        loading,
    output logic        load_done,
    input  logic        wr_en,
    input  logic [9:0]  wr_x,
    input  logic [9:0]  wr_y,
    input  logic [2:0]  wr_type,
    input  logic [9:0]  x1,
    input  logic [9:0]  y1,
    output logic [2:0]  blockType1,
    input  logic [9:0]  x2,
    input  logic [9:0]  y2,
    output logic [2:0]  blockType2
);
    localparam int         N     = MAP_W * MAP_H;
    localparam logic [9:0] PIX_W = 10'(MAP_W * 32);
    localparam logic [9:0] PIX_H = 10'(MAP_H * 32);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [10:0] rom_addr_q, rom_addr_d;
    logic        loading_q, loading_d;
    logic        load_done_q, load_done_d;
    logic [2:0]  map_q [N];
    logic [2:0]  map_d [N];

    function automatic logic in_bounds(input logic [9:0] x, input logic [9:0] y);
        return (x < PIX_W) && (y < PIX_H);
    endfunction

    function automatic logic [8:0] tile_idx(input logic [9:0] x, input logic [9:0] y);
        return 9'(y[9:5]) * 9'(MAP_W) + 9'(x[9:5]);
    endfunction

    // Wrapped negative coordinates land at >= 640/480 and fall into the OOB branch.
    assign blockType1 = (loading_q || !in_bounds(x1, y1)) ? OOB_TYPE : map_q[tile_idx(x1, y1)];
    assign blockType2 = (loading_q || !in_bounds(x2, y2)) ? OOB_TYPE : map_q[tile_idx(x2, y2)];

    assign rom_addr  = rom_addr_q;
    assign loading   = loading_q;
    assign load_done = load_done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        map_d      = map_q;

        if (wr_en && !loading_q && in_bounds(wr_x, wr_y)) begin
            map_d[tile_idx(wr_x, wr_y)] = wr_type;
        end

        case (state_q)
            IDLE: begin
                if (load_req) begin
                    rom_addr_d = 11'(level_sel) * 11'(N);
                    cnt_d      = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                // ROM data lags the address by one cycle, so entry cnt-1 lands now.
                if (cnt_q != 9'd0) begin
                    map_d[cnt_q - 9'd1] = rom_data;
                end
                if (cnt_q < 9'(N - 1)) begin
                    cnt_d      = cnt_q + 9'd1;
                    rom_addr_d = rom_addr_q + 11'd1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                map_d[N - 1] = rom_data;
                state_d      = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        loading_d   = (state_d == FILL) || (state_d == DRAIN);
        load_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rom_addr_q  <= '0;
            loading_q   <= 1'b0;
            load_done_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                map_q[i] <= 3'd0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rom_addr_q  <= rom_addr_d;
            loading_q   <= loading_d;
            load_done_q <= load_done_d;
            map_q       <= map_d;
        end
    end
endmodule

// File: tb/tb_tile_map_server.sv
// Directed bench for tile_map_server with a registered level-ROM model.
module tb_tile_map_server;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic [1:0]  level_sel;
    logic [10:0] rom_addr;
    logic [2:0]  rom_data = 3'd0;
    logic        loading;
    logic        load_done;
    logic        wr_en;
    logic [9:0]  wr_x, wr_y;
    logic [2:0]  wr_type;
    logic [9:0]  x1, y1, x2, y2;
    logic [2:0]  blockType1, blockType2;

    int n_checks = 0;
    int n_fails  = 0;

    tile_map_server dut (
        .clk(clk), .rst(rst), .load_req(load_req), .level_sel(level_sel),
        .rom_addr(rom_addr), .rom_data(rom_data), .loading(loading), .load_done(load_done),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_type(wr_type),
        .x1(x1), .y1(y1), .blockType1(blockType1),
        .x2(x2), .y2(y2), .blockType2(blockType2)
    );

    always #5 clk = ~clk;

    // Level 2 holds i mod 8; every other level holds (i+3) mod 8.
    function automatic logic [2:0] rom_fn(input logic [10:0] a);
        int lvl = int'(a) / 300;
        int i   = int'(a) % 300;
        return (lvl == 2) ? 3'(i % 8) : 3'((i + 3) % 8);
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic query(input int ax1, input int ay1, input int ax2, input int ay2);
        x1 = 10'(ax1); y1 = 10'(ay1);
        x2 = 10'(ax2); y2 = 10'(ay2);
        #1;
    endtask

    initial begin
        int cyc;
        rst = 1'b1; load_req = 1'b0; level_sel = 2'd0;
        wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_type = '0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_loading", 32'(loading), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        query(100, 100, 700, 10);
        chk("rst_q1_inb", 32'(blockType1), 0);
        chk("rst_q2_oob", 32'(blockType2), 1);

        // Level 2 load; cycle 0 is the load_req cycle
        level_sel = 2'd2; load_req = 1'b1;
        tick(); load_req = 1'b0; cyc = 1;
        chk("ld_first_addr", 32'(rom_addr), 600);
        chk("ld_loading_c1", 32'(loading), 1);
        while (cyc < 100) begin tick(); cyc++; end
        query(100, 100, 64, 32);
        chk("midload_q1", 32'(blockType1), 1);
        chk("midload_q2", 32'(blockType2), 1);
        wr_en = 1'b1; wr_x = 10'd64; wr_y = 10'd32; wr_type = 3'd7;
        load_req = 1'b1; level_sel = 2'd0;
        tick(); cyc++;
        wr_en = 1'b0; load_req = 1'b0; level_sel = 2'd2;
        chk("ign_req_addr", 32'(rom_addr), 700);
        chk("ign_req_loading", 32'(loading), 1);
        while (cyc < 300) begin tick(); cyc++; end
        chk("ld_last_addr", 32'(rom_addr), 899);
        tick(); cyc++;
        chk("ld_loading_c301", 32'(loading), 1);
        chk("ld_done_c301", 32'(load_done), 0);
        tick(); cyc++;
        chk("ld_done_c302", 32'(load_done), 1);
        chk("ld_loading_c302", 32'(loading), 0);
        tick();
        chk("ld_done_c303", 32'(load_done), 0);

        query(64, 32, 639, 479);
        chk("q_idx22", 32'(blockType1), 6);
        chk("q_idx299", 32'(blockType2), 3);
        query(1023, 40, 0, 40);
        chk("wrap_q1", 32'(blockType1), 1);
        chk("wrap_q2_idx20", 32'(blockType2), 4);
        query(200, 300, 200, 300);
        chk("same_tile_both_ports", 32'(blockType2), 2);

        // Runtime write: old value in the write cycle, new value after
        wr_en = 1'b1; wr_x = 10'd200; wr_y = 10'd300; wr_type = 3'd0;
        query(200, 300, 210, 310);
        chk("wr_same_cycle", 32'(blockType1), 2);
        tick(); wr_en = 1'b0;
        query(200, 300, 210, 310);
        chk("wr_next_q1", 32'(blockType1), 0);
        chk("wr_next_q2", 32'(blockType2), 0);

        // OOB write must not alias onto tile 20 or anywhere else
        wr_en = 1'b1; wr_x = 10'd650; wr_y = 10'd0; wr_type = 3'd5;
        tick(); wr_en = 1'b0;
        query(0, 40, 639, 0);
        chk("oob_wr_idx20", 32'(blockType1), 4);
        chk("oob_wr_idx19", 32'(blockType2), 3);
        query(650, 0, 0, 0);
        chk("oob_wr_q1", 32'(blockType1), 1);
        chk("oob_wr_idx0", 32'(blockType2), 0);

        // Reset in the middle of a level-1 load
        level_sel = 2'd1; load_req = 1'b1;
        tick(); load_req = 1'b0; cyc = 1;
        chk("ld1_first_addr", 32'(rom_addr), 300);
        while (cyc < 150) begin tick(); cyc++; end
        rst = 1'b1;
        #1;
        chk("rst_mid_loading", 32'(loading), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_mid_no_done", 32'(load_done), 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_rel_no_done", 32'(load_done), 0);
        end
        chk("rst_rel_loading", 32'(loading), 0);
        for (int ty = 0; ty < 15; ty++) begin
            for (int tx = 0; tx < 20; tx++) begin
                query(tx * 32 + 5, ty * 32 + 7, tx * 32 + 31, ty * 32);
                chk("cleared_q1", 32'(blockType1), 0);
                chk("cleared_q2", 32'(blockType2), 0);
            end
        end

        // Fresh load completes normally
        level_sel = 2'd1; load_req = 1'b1;
        tick(); load_req = 1'b0; cyc = 1;
        chk("reld_first_addr", 32'(rom_addr), 300);
        while (!load_done && cyc < 400) begin tick(); cyc++; end
        chk("reld_done_cycle", 32'(cyc), 302);
        chk("reld_loading", 32'(loading), 0);
        query(200, 300, 639, 479);
        chk("reld_idx186", 32'(blockType1), 5);
        chk("reld_idx299", 32'(blockType2), 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/tile_map_server.md
# tile_map_server

Holds the current level's 20×15 tile map (32×32 px tiles, 640×480 playfield) and answers the pixel-coordinate block-type queries issued by `collision_resolver` on its two lookup ports. A loader state machine fills the map from the level ROM on request. A single-tile write port lets game logic change tiles at runtime, for example clearing a destroyed block.

## Interface
- `MAP_W`, 20, map width in tiles
- `MAP_H`, 15, map height in tiles
- `OOB_TYPE`, 3'd1, block type returned for any out-of-bounds or mid-load query (solid)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `load_req`  in  1  one-cycle pulse; starts loading level `level_sel`
- `level_sel`  in  2  level index, sampled on the `load_req` cycle
- `rom_addr`  out  11  level ROM address
- `rom_data`  in  3  level ROM data, valid one cycle after `rom_addr`
- `loading`  out  1  high while the loader is active
- `load_done`  out  1  one-cycle pulse when the map is complete
- `wr_en`  in  1  tile write strobe
- `wr_x`, `wr_y`  in  10 each  pixel coordinate of the tile to write
- `wr_type`  in  3  new block type
- `x1`, `y1`  in  10 each  query port 1 coordinate (player/lizard/campfire/block resolvers)
- `blockType1`  out  3  block type at (`x1`,`y1`)
- `x2`, `y2`  in  10 each  query port 2 coordinate (blade resolver)
- `blockType2`  out  3  block type at (`x2`,`y2`)

## Operation
- **Storage:** 300 entries × 3 bits, held in flops.
  - Tile index = ty*20 + tx, where tx = x[9:5] and ty = y[9:5].
  - Block types: 0 air, 1 solid, 2 one-way platform, 3 pass-through; 4–7 are stored verbatim.
- **Query ports:** purely combinational from `x`/`y` to `blockType`, with no register stage. The resolvers present a coordinate and sample the type in the same cycle.
  - Out of bounds (x ≥ 640 or y ≥ 480) returns `OOB_TYPE`. This includes coordinates that underflowed below 0 and wrapped to large values.
  - While `loading` = 1, both ports return `OOB_TYPE`.
- **Loader FSM:**
  - IDLE: on `load_req`, latch base = `level_sel`*300, set cnt = 0 and `rom_addr` = base, then go to FILL.
  - FILL: each cycle, write `rom_data` to entry cnt−1 when cnt > 0; if cnt < 299, increment cnt and `rom_addr`; when cnt = 299, go to DRAIN.
  - DRAIN: write `rom_data` to entry 299, then go to DONE.
  - DONE: pulse `load_done`, then go to IDLE.
  - `loading` = 1 in FILL and DRAIN.
- **Write port:**
  - When `wr_en` = 1 with an in-bounds coordinate and `loading` = 0, the tile at (`wr_x`[9:5], `wr_y`[9:5]) takes `wr_type` on the clock edge.
  - Out-of-bounds writes are ignored.
  - Writes while `loading` = 1 are ignored.
- `load_req` while `loading` = 1 or in DONE is ignored.

## Timing
- **Reset values:** all map entries 0; FSM in IDLE; `rom_addr` 0; `loading` 0; `load_done` 0.
  - `blockType` outputs therefore read 0 for in-bounds queries and `OOB_TYPE` for out-of-bounds queries.
- **Load latency:**
  - `load_req` at cycle 0 → `rom_addr` = base at cycle 1, and `loading` = 1 from cycle 1.
  - The last ROM address, base+299, is presented at cycle 300.
  - The final entry is written at the end of cycle 301.
  - `load_done` = 1 in cycle 302, with `loading` = 0 in that same cycle.
- **Write timing:** a write is visible on the query ports the cycle after `wr_en`. A query to the same tile in the write cycle returns the old value.
- **Read ports:** independent; both may address the same tile in the same cycle.
- **Reset mid-load:** the FSM returns to IDLE and the map is cleared to all 0. No `load_done` pulse is issued.

## Test plan
- **Reset/query:** reset, then query (100,100) and (700,10) → `blockType1` = 0, `blockType2` = 1.
- **Level load:** ROM model with level 2 containing entry i = i mod 8; pulse `load_req` with `level_sel` = 2.
  - First `rom_addr` = 600, last = 899; `load_done` 302 cycles after `load_req`.
  - Then query (64,32), i.e. index 22 → 6; query (639,479), i.e. index 299 → 3.
- **Query during load:** mid-load, query any in-bounds coordinate → `OOB_TYPE` on both ports. A `wr_en` issued mid-load leaves that tile unchanged after load.
- **Runtime write:** after load, write type 0 at (200,300); query the same tile in the same cycle → old value; query next cycle → 0.
  - A write to (650,0) changes nothing.
- **Wraparound:** query x = 1023 (underflowed −1), y = 40 → 1 on port 1. Simultaneously query port 2 at (0,40) → loaded value of tile 20.
- **Reset mid-load:** assert `rst` at cycle 150 of a load → `loading` = 0, no `load_done`, all in-bounds queries return 0. A new `load_req` then completes normally.
